// File: rtl/div_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : div_pkg                                                       |
// | Brief    : Shared state encoding and sizing for the sequential divider.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +--------------------------------------------------------------------------+
// | Module   : div_step                                                      |
// | Brief    : One restoring-division step: shift in a dividend bit, trial   |
// |            subtract the divisor, keep or restore, emit one quotient bit. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    input  logic             i_msb,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_diff;
    logic             w_cout;

    // The shifted partial remainder is WIDTH+1 bits; its top bit is i_rem's MSB.
    // When that bit is set the value already exceeds any divisor, and the
    // WIDTH-bit difference wraps to the correct result.
    assign w_low            = {i_rem[WIDTH-2:0], i_msb};
    assign {w_cout, w_diff} = {1'b0, w_low} + {1'b0, ~i_dvs} + {{WIDTH{1'b0}}, 1'b1};
    assign o_qbit           = i_rem[WIDTH-1] | w_cout;
    assign o_rem            = o_qbit ? w_diff : w_low;

endmodule

`default_nettype wire

// File: rtl/seq_divider_32.sv
// +--------------------------------------------------------------------------+
// | Module   : seq_divider_32                                                |
// | Brief    : Multi-cycle restoring divider with start/done handshake.      |
// |            Define SIGNED_DIV_EN for two's-complement operands.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_divider_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               C_CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_CW-1:0]  C_LAST = C_CW'(WIDTH - 1);

    div_state_e       r_state_q, w_state_d;
    logic [C_CW-1:0]  r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0] r_rem_q, w_rem_d;
    logic [WIDTH-1:0] r_quo_q, w_quo_d;
    logic [WIDTH-1:0] r_dvs_q, w_dvs_d;
    logic             r_busy_q, w_busy_d;
    logic             r_done_q, w_done_d;
    logic [WIDTH-1:0] r_quotient_q, w_quotient_d;
    logic [WIDTH-1:0] r_remainder_q, w_remainder_d;
    logic             r_dbz_q, w_dbz_d;

    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_res_q;
    logic [WIDTH-1:0] w_res_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem_q),
        .i_dvs  (r_dvs_q),
        .i_msb  (r_quo_q[WIDTH-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    assign w_step_quo = {r_quo_q[WIDTH-2:0], w_step_qbit};

`ifdef SIGNED_DIV_EN
    logic r_qneg_q, w_qneg_d;
    logic r_rneg_q, w_rneg_d;

    // -2^(W-1) maps onto itself, which is still the right unsigned magnitude.
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + C_ONE) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor + C_ONE)  : divisor;
    assign w_res_q   = r_qneg_q ? (~w_step_quo + C_ONE) : w_step_quo;
    assign w_res_r   = r_rneg_q ? (~w_step_rem + C_ONE) : w_step_rem;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_res_q   = w_step_quo;
    assign w_res_r   = w_step_rem;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_rem_d       = r_rem_q;
        w_quo_d       = r_quo_q;
        w_dvs_d       = r_dvs_q;
        w_busy_d      = r_busy_q;
        w_done_d      = 1'b0;
        w_quotient_d  = r_quotient_q;
        w_remainder_d = r_remainder_q;
        w_dbz_d       = r_dbz_q;
`ifdef SIGNED_DIV_EN
        w_qneg_d      = r_qneg_q;
        w_rneg_d      = r_rneg_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_busy_d = 1'b1;
                    w_cnt_d  = '0;
                    if (divisor == '0) begin
                        // Zero divisor skips the iteration; results are loaded now.
                        w_state_d     = DONE;
                        w_done_d      = 1'b1;
                        w_quotient_d  = '1;
                        w_remainder_d = dividend;
                        w_dbz_d       = 1'b1;
                    end else begin
                        w_state_d = CALC;
                        w_rem_d   = '0;
                        w_quo_d   = w_dvd_mag;
                        w_dvs_d   = w_dvs_mag;
`ifdef SIGNED_DIV_EN
                        w_qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        w_rneg_d  = dividend[WIDTH-1];
`endif
                    end
                end
            end
            CALC: begin
                w_rem_d = w_step_rem;
                w_quo_d = w_step_quo;
                w_cnt_d = r_cnt_q + C_CW'(1);
                if (r_cnt_q == C_LAST) begin
                    w_state_d     = DONE;
                    w_done_d      = 1'b1;
                    w_quotient_d  = w_res_q;
                    w_remainder_d = w_res_r;
                    w_dbz_d       = 1'b0;
                end
            end
            DONE: begin
                w_state_d = IDLE;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_rem_q       <= '0;
            r_quo_q       <= '0;
            r_dvs_q       <= '0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_quotient_q  <= '0;
            r_remainder_q <= '0;
            r_dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_qneg_q      <= 1'b0;
            r_rneg_q      <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_rem_q       <= w_rem_d;
            r_quo_q       <= w_quo_d;
            r_dvs_q       <= w_dvs_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
            r_quotient_q  <= w_quotient_d;
            r_remainder_q <= w_remainder_d;
            r_dbz_q       <= w_dbz_d;
`ifdef SIGNED_DIV_EN
            r_qneg_q      <= w_qneg_d;
            r_rneg_q      <= w_rneg_d;
`endif
        end
    end

    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign quotient    = r_quotient_q;
    assign remainder   = r_remainder_q;
    assign div_by_zero = r_dbz_q;

endmodule

`default_nettype wire
